// File: rtl/any1_ialign_buf.sv
// Two-line instruction fetch/align buffer between the I-cache and decode.
// Optional same-cycle line-to-instruction bypass: define ANY1_IALIGN_BYPASS_EN.
module any1_ialign_buf #(
  parameter int LINE_BYTES = 64,
  parameter int IBYTES     = 5,
  parameter int AW         = 32
) (
  input  logic                    rst_ni,
  input  logic                    clk_i,
  input  logic                    flush_i,
  input  logic [AW-1:0]           flush_ip_i,
  input  logic                    line_v_i,
  output logic                    line_rdy_o,
  input  logic [AW-1:0]           line_adr_i,
  input  logic [LINE_BYTES*8-1:0] line_i,
  input  logic                    line_pt_i,
  output logic                    ir_v_o,
  input  logic                    ir_rdy_i,
  output logic [IBYTES*8-1:0]     ir_o,
  output logic [AW-1:0]           ip_o,
  output logic                    pt_o
);

  localparam int OB = $clog2(LINE_BYTES);
  localparam int LW = AW - OB;
  localparam int DW = LINE_BYTES * 8;
  localparam int IW = IBYTES * 8;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ip_q, ip_d;
  logic [DW-1:0]   cur_data_q, cur_data_d, nxt_data_q, nxt_data_d;
  logic [LW-1:0]   cur_line_q, cur_line_d, nxt_line_q, nxt_line_d;
  logic            cur_pt_q, cur_pt_d, nxt_pt_q, nxt_pt_d;

  logic [OB-1:0]   off;
  logic [LW-1:0]   ip_line, in_line;
  logic            fits, buf_v, byp_hit, consume, accept;
  logic [IW-1:0]   buf_ir;
  logic            unused_adr_bits;

  assign off             = ip_q[OB-1:0];
  assign ip_line         = ip_q[AW-1:OB];
  assign in_line         = line_adr_i[AW-1:OB];
  assign unused_adr_bits = ^line_adr_i[OB-1:0];

  // An instruction that fits in one line needs only cur; a straddler needs nxt as well.
  assign fits   = off <= OB'(LINE_BYTES - IBYTES);
  assign buf_v  = fits ? (state_q != EMPTY && cur_line_q == ip_line) : (state_q == TWO);
  assign buf_ir = IW'({nxt_data_q, cur_data_q} >> {off, 3'b000});

`ifdef ANY1_IALIGN_BYPASS_EN
  assign byp_hit = state_q == EMPTY && line_v_i && in_line == ip_line && fits;
  assign ir_o    = byp_hit ? IW'(line_i >> {off, 3'b000}) : buf_ir;
  assign pt_o    = byp_hit ? line_pt_i : cur_pt_q;
`else
  assign byp_hit = 1'b0;
  assign ir_o    = buf_ir;
  assign pt_o    = cur_pt_q;
`endif

  assign ir_v_o     = rst_ni && (buf_v || byp_hit);
  assign ip_o       = ip_q;
  assign line_rdy_o = rst_ni && (state_q != TWO);
  assign consume    = ir_v_o && ir_rdy_i;
  assign accept     = line_v_i && line_rdy_o;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_d    = state_q;
    ip_d       = ip_q;
    cur_data_d = cur_data_q;
    cur_line_d = cur_line_q;
    cur_pt_d   = cur_pt_q;
    nxt_data_d = nxt_data_q;
    nxt_line_d = nxt_line_q;
    nxt_pt_d   = nxt_pt_q;

    if (flush_i) begin
      ip_d    = flush_ip_i;
      state_d = EMPTY;
    end else begin
      if (consume) begin
        if (byp_hit) begin
          cur_data_d = line_i;
          cur_line_d = in_line;
          cur_pt_d   = line_pt_i;
          state_d    = ONE;
        end
        ip_d = ip_q + AW'(IBYTES);
        // Leaving cur: promote nxt if held, otherwise the window drains.
        if (ip_d[AW-1:OB] != cur_line_d) begin
          if (state_d == TWO) begin
            cur_data_d = nxt_data_q;
            cur_line_d = nxt_line_q;
            cur_pt_d   = nxt_pt_q;
            state_d    = ONE;
          end else begin
            state_d = EMPTY;
          end
        end
      end

      // Incoming line is matched against the expected address after any shift.
      if (accept && !(consume && byp_hit)) begin
        case (state_d)
          EMPTY: begin
            if (in_line == ip_d[AW-1:OB]) begin
              cur_data_d = line_i;
              cur_line_d = in_line;
              cur_pt_d   = line_pt_i;
              state_d    = ONE;
            end
          end
          ONE: begin
            if (in_line == cur_line_d + LW'(1)) begin
              nxt_data_d = line_i;
              nxt_line_d = in_line;
              nxt_pt_d   = line_pt_i;
              state_d    = TWO;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      ip_q       <= '0;
      // NOTE: line data is reset too, so ir_o reads as zero out of reset.
      cur_data_q <= '0;
      cur_line_q <= '0;
      cur_pt_q   <= 1'b0;
      nxt_data_q <= '0;
      nxt_line_q <= '0;
      nxt_pt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ip_q       <= ip_d;
      cur_data_q <= cur_data_d;
      cur_line_q <= cur_line_d;
      cur_pt_q   <= cur_pt_d;
      nxt_data_q <= nxt_data_d;
      nxt_line_q <= nxt_line_d;
      nxt_pt_q   <= nxt_pt_d;
    end
  end

endmodule

// File: tb/tb_any1_ialign_buf.sv
// Self-checking bench for any1_ialign_buf: directed scenarios plus random traffic
// checked against a byte-addressed model of the held lines.
module tb_any1_ialign_buf;

  localparam int LB = 64;
  localparam int IB = 5;
  localparam int AW = 32;
  localparam int DW = LB * 8;
  localparam int IW = IB * 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] flush_ip = '0;
  logic          line_v = 1'b0;
  logic          line_rdy;
  logic [AW-1:0] line_adr = '0;
  logic [DW-1:0] line_d = '0;
  logic          line_pt = 1'b0;
  logic          ir_v;
  logic          ir_rdy = 1'b0;
  logic [IW-1:0] ir;
  logic [AW-1:0] ip;
  logic          pt;

  always #5 clk = ~clk;

  any1_ialign_buf #(.LINE_BYTES(LB), .IBYTES(IB), .AW(AW)) dut (
    .rst_ni     (rst_n),
    .clk_i      (clk),
    .flush_i    (flush),
    .flush_ip_i (flush_ip),
    .line_v_i   (line_v),
    .line_rdy_o (line_rdy),
    .line_adr_i (line_adr),
    .line_i     (line_d),
    .line_pt_i  (line_pt),
    .ir_v_o     (ir_v),
    .ir_rdy_i   (ir_rdy),
    .ir_o       (ir),
    .ip_o       (ip),
    .pt_o       (pt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the list of held lines (oldest first) and the fetch IP.
  typedef struct packed {
    logic [AW-1:0] base;
    logic [DW-1:0] data;
    logic          pt;
  } line_t;

  line_t         q[$];
  logic [AW-1:0] m_ip = '0;

  function automatic logic [AW-1:0] lbase(input logic [AW-1:0] a);
    return a & ~AW'(LB - 1);
  endfunction

  function automatic line_t offered();
    line_t l;
    l.base = lbase(line_adr);
    l.data = line_d;
    l.pt   = line_pt;
    return l;
  endfunction

  // Instruction is visible when the line holding ip leads the list and every byte is held.
  task automatic model_out(output logic v, output logic [IW-1:0] e_ir, output logic e_pt);
    line_t         w[$];
    logic          ok, found;
    logic [AW-1:0] a;
    w = q;
    v = 1'b0; e_ir = '0; e_pt = 1'b0;
`ifdef ANY1_IALIGN_BYPASS_EN
    if (q.size() == 0 && line_v && lbase(line_adr) == lbase(m_ip)) w.push_back(offered());
`endif
    if (rst_n && w.size() > 0 && w[0].base == lbase(m_ip)) begin
      ok = 1'b1;
      for (int i = 0; i < IB; i++) begin
        a = m_ip + AW'(i);
        found = 1'b0;
        foreach (w[j]) begin
          if (w[j].base == lbase(a)) begin
            e_ir[i*8 +: 8] = w[j].data[(a - w[j].base)*8 +: 8];
            found = 1'b1;
          end
        end
        if (!found) ok = 1'b0;
      end
      v = ok;
      e_pt = w[0].pt;
    end
  endtask

  task automatic model_step();
    logic          v, e_pt, rdy, took;
    logic [IW-1:0] e_ir;
    logic [AW-1:0] expa;
    if (!rst_n) begin
      q.delete();
      m_ip = '0;
    end else if (flush) begin
      q.delete();
      m_ip = flush_ip;
    end else begin
      rdy  = q.size() < 2;
      took = 1'b0;
      model_out(v, e_ir, e_pt);
      if (v && ir_rdy) begin
        if (q.size() == 0) begin
          q.push_back(offered());
          took = 1'b1;
        end
        m_ip = m_ip + AW'(IB);
        if (q.size() > 0 && q[0].base != lbase(m_ip)) void'(q.pop_front());
      end
      if (line_v && rdy && !took) begin
        expa = (q.size() == 0) ? lbase(m_ip) : q[$].base + AW'(LB);
        if (lbase(line_adr) == expa) q.push_back(offered());
      end
    end
  endtask

  // Compare outputs mid-cycle, then advance DUT and model across one rising edge.
  task automatic tick();
    logic          v, e_pt;
    logic [IW-1:0] e_ir;
    @(negedge clk);
    model_out(v, e_ir, e_pt);
    check("ir_v", ir_v, v);
    check("line_rdy", line_rdy, rst_n && (q.size() < 2));
    check("ip", ip, m_ip);
    if (v) begin
      check("ir", ir, e_ir);
      check("pt", pt, e_pt);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] a, input logic [7:0] b0, input logic p);
    line_v   = 1'b1;
    line_adr = a;
    line_pt  = p;
    for (int k = 0; k < LB; k++) line_d[k*8 +: 8] = b0 + 8'(k);
  endtask

  function automatic logic [AW-1:0] pick_ip();
    logic [AW-1:0] base;
    case ($urandom_range(0, 2))
      0:       base = 32'h0000_1000;
      1:       base = 32'h0000_2000;
      default: base = 32'hFFFF_FFC0;
    endcase
    if ($urandom_range(0, 1) == 1) return base + AW'($urandom_range(LB - IB + 1, LB - 1));
    return base + AW'($urandom_range(0, LB - 1));
  endfunction

  logic [IW-1:0] hold_ir;
  logic [AW-1:0] exp_adr;

  initial begin
    // Reset
    tick(); tick();
    check("rst_rdy_low", line_rdy, 1'b0);
    check("rst_ir_v", ir_v, 1'b0);
    check("rst_ip", ip, 32'h0);
    check("rst_ir", ir, 40'h0);
    check("rst_pt", pt, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_rdy_high", line_rdy, 1'b1);

    // Sequential fetch
    flush = 1'b1; flush_ip = 32'h1000; tick(); flush = 1'b0;
    offer(32'h1000, 8'h00, 1'b1); ir_rdy = 1'b0; tick(); line_v = 1'b0; ir_rdy = 1'b1;
    check("seq_v0", ir_v, 1'b1);
    check("seq_ir0", ir, 40'h04_0302_0100);
    check("seq_ip0", ip, 32'h1000);
    check("seq_pt0", pt, 1'b1);
    tick();
    check("seq_ir1", ir, 40'h09_0807_0605);
    check("seq_ip1", ip, 32'h1005);
    repeat (11) tick();
    check("seq_ip_end", ip, 32'h103C);
    check("seq_v_end", ir_v, 1'b0);
    offer(32'h1040, 8'h40, 1'b0); tick(); line_v = 1'b0;
    check("seq_str_v", ir_v, 1'b1);
    check("seq_str_ir", ir, 40'h40_3F3E_3D3C);

    // Straddle
    flush = 1'b1; flush_ip = 32'h103E; tick(); flush = 1'b0;
    offer(32'h1000, 8'h00, 1'b0); tick(); line_v = 1'b0;
    check("str_wait0", ir_v, 1'b0);
    tick();
    check("str_wait1", ir_v, 1'b0);
    offer(32'h1040, 8'h40, 1'b1); tick(); line_v = 1'b0;
    check("str_v", ir_v, 1'b1);
    check("str_ir", ir, 40'h42_4140_3F3E);
    check("str_ip", ip, 32'h103E);
    check("str_pt", pt, 1'b0);
    tick();
    check("str_next_ip", ip, 32'h1043);
    check("str_next_ir", ir, 40'h47_4645_4443);
    check("str_one_rdy", line_rdy, 1'b1);

    // Stale drop
    flush = 1'b1; flush_ip = 32'h2000; tick(); flush = 1'b0;
    offer(32'h1040, 8'h00, 1'b0);
    check("stale_rdy", line_rdy, 1'b1);
    tick(); line_v = 1'b0;
    check("stale_v", ir_v, 1'b0);
    check("stale_rdy_after", line_rdy, 1'b1);
    ir_rdy = 1'b0;
    offer(32'h2000, 8'h80, 1'b1); tick(); line_v = 1'b0;
    check("stale_good_v", ir_v, 1'b1);
    check("stale_good_ip", ip, 32'h2000);

    // Backpressure
    hold_ir = ir;
    offer(32'h2040, 8'hC0, 1'b0); tick(); line_v = 1'b0;
    check("bp_rdy", line_rdy, 1'b0);
    repeat (3) begin
      tick();
      check("bp_ir", ir, hold_ir);
      check("bp_ip", ip, 32'h2000);
      check("bp_pt", pt, 1'b1);
    end

    // Flush collision, first with the window full, then with an empty window
    flush = 1'b1; flush_ip = 32'h3000; ir_rdy = 1'b1;
    offer(32'h3000, 8'h00, 1'b1); tick();
    check("coll_ip", ip, 32'h3000);
    check("coll_v", ir_v, 1'b0);
    tick(); flush = 1'b0; line_v = 1'b0;
    check("coll_drop_v", ir_v, 1'b0);
    check("coll_drop_rdy", line_rdy, 1'b1);
    tick();
    check("coll_still_empty", ir_v, 1'b0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      rst_n  = $urandom_range(0, 399) != 0;
      flush  = $urandom_range(0, 29) == 0;
      if (flush) flush_ip = pick_ip();
      ir_rdy = $urandom_range(0, 9) < 7;
      line_v = $urandom_range(0, 9) < 6;
      exp_adr = (q.size() == 0) ? lbase(m_ip) : q[$].base + AW'(LB);
      if ($urandom_range(0, 4) == 0)
        line_adr = exp_adr + AW'(LB * $urandom_range(1, 3));
      else
        line_adr = exp_adr | AW'($urandom_range(0, LB - 1));
      for (int k = 0; k < DW / 32; k++) line_d[k*32 +: 32] = $urandom;
      line_pt = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
